demultiplexer_4_seq: RTL and testbench

//  Sequenced 1-to-4 demultiplexer: routes a WIDTH-bit input into one of four held

---
 rtl/demux4_pkg.sv | 18 +
 rtl/demux4_lane_reg.sv | 20 ++
 rtl/demultiplexer_4_seq.sv | 135 +++++++++++++
 tb/tb_demultiplexer_4_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared definitions for the sequenced 1-to-4 demultiplexer: lane count,
// select width and FSM state encodings.
package demux4_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } demuxState_e;

  function automatic logic [LANES-1:0] laneOneHot(input logic [SEL_W-1:0] lane);
    return LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/demux4_lane_reg.sv
// One held lane register of the 1-to-4 demultiplexer: captures wrData when
// writeEn is high, otherwise holds; synchronous active-high reset.
module demux4_lane_reg
  import demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             sysclk,
  input  logic             sys_rst,
  input  logic             writeEn,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] laneData
);

  always_ff @(posedge sysclk) begin
    if (sys_rst)      laneData <= '0;
    else if (writeEn) laneData <= wrData;
  end

endmodule

// File: rtl/demultiplexer_4_seq.sv
// Sequenced 1-to-4 demultiplexer with frame tracking. Optional frame parity
// output is enabled by defining DEMUX4_PARITY_EN.
//
// state | meaning
// IDLE  | no lane written in the current frame
// FILL  | at least one lane written, frame not yet complete
// FULL  | frame just completed; frame_valid high for this single cycle
module demultiplexer_4_seq
  import demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             sysclk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] demuxIn,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic             auto_mode,
  input  logic             clear,
  output logic [WIDTH-1:0] demuxOut_0,
  output logic [WIDTH-1:0] demuxOut_1,
  output logic [WIDTH-1:0] demuxOut_2,
  output logic [WIDTH-1:0] demuxOut_3,
  output logic [LANES-1:0] lane_valid,
  output logic [SEL_W-1:0] seq_idx,
  output logic             frame_valid
`ifdef DEMUX4_PARITY_EN
  ,
  output logic [WIDTH-1:0] frame_parity
`endif
);

  demuxState_e      state, nextState;
  logic [LANES-1:0] laneValidNext;
  logic [SEL_W-1:0] seqIdxNext;
  logic             frameValidNext;
  logic             autoPrev;

  logic [SEL_W-1:0] targetLane;
  logic [LANES-1:0] laneHit;
  logic [LANES-1:0] filled;
  logic [LANES-1:0] writeEn;
  logic             modeChange;
  logic             abort;
  logic             accept;

  logic [WIDTH-1:0] laneQ [LANES];

  for (genvar i = 0; i < LANES; i++) begin : gLane
    demux4_lane_reg #(.WIDTH(WIDTH)) uLane (
      .sysclk   (sysclk),
      .sys_rst  (sys_rst),
      .writeEn  (writeEn[i]),
      .wrData   (demuxIn),
      .laneData (laneQ[i])
    );
  end

  assign demuxOut_0 = laneQ[0];
  assign demuxOut_1 = laneQ[1];
  assign demuxOut_2 = laneQ[2];
  assign demuxOut_3 = laneQ[3];

  // A mode flip only aborts a frame in progress; in IDLE/FULL the load proceeds.
  always_comb begin
    modeChange = auto_mode != autoPrev;
    targetLane = auto_mode ? seq_idx : sel;
    laneHit    = laneOneHot(targetLane);
    abort      = clear | (modeChange & (state == FILL));
    accept     = load & ~abort;
    writeEn    = accept ? laneHit : '0;
    filled     = lane_valid | laneHit;
  end

  always_comb begin
    nextState      = state;
    laneValidNext  = lane_valid;
    seqIdxNext     = seq_idx;
    frameValidNext = 1'b0;
    if (abort) begin
      nextState     = IDLE;
      laneValidNext = '0;
      seqIdxNext    = '0;
    end else if (accept) begin
      if (filled == '1) begin
        nextState      = FULL;
        laneValidNext  = '0;
        seqIdxNext     = '0;
        frameValidNext = 1'b1;
      end else begin
        nextState     = FILL;
        laneValidNext = filled;
        if (auto_mode) seqIdxNext = seq_idx + SEL_W'(1);
      end
    end else if (state == FULL) begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state       <= IDLE;
      lane_valid  <= '0;
      seq_idx     <= '0;
      frame_valid <= 1'b0;
      autoPrev    <= 1'b0;
    end else begin
      state       <= nextState;
      lane_valid  <= laneValidNext;
      seq_idx     <= seqIdxNext;
      frame_valid <= frameValidNext;
      autoPrev    <= auto_mode;
    end
  end

`ifdef DEMUX4_PARITY_EN
  logic [WIDTH-1:0] postWriteXor;

  // Parity must reflect the lane contents after this edge's write.
  always_comb begin
    postWriteXor = '0;
    for (int i = 0; i < LANES; i++)
      postWriteXor = postWriteXor ^ (writeEn[i] ? demuxIn : laneQ[i]);
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst)             frame_parity <= '0;
    else if (abort)          frame_parity <= '0;
    else if (frameValidNext) frame_parity <= postWriteXor;
  end
`else
  // Parity disabled: no frame_parity port or logic.
`endif

endmodule

// File: tb/tb_demultiplexer_4_seq.sv
// Self-checking bench for demultiplexer_4_seq (WIDTH=4): vector table driven
// through a scoreboard queue, then a back-to-back auto-mode frame sequence.
module tb_demultiplexer_4_seq;

  logic       sysclk = 1'b0;
  logic       sys_rst, load, auto_mode, clear;
  logic [1:0] sel;
  logic [3:0] demuxIn;
  logic [3:0] demuxOut_0, demuxOut_1, demuxOut_2, demuxOut_3;
  logic [3:0] lane_valid;
  logic [1:0] seq_idx;
  logic       frame_valid;
`ifdef DEMUX4_PARITY_EN
  logic [3:0] frame_parity;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  demultiplexer_4_seq #(.WIDTH(4)) dut (
    .sysclk      (sysclk),
    .sys_rst     (sys_rst),
    .demuxIn     (demuxIn),
    .sel         (sel),
    .load        (load),
    .auto_mode   (auto_mode),
    .clear       (clear),
    .demuxOut_0  (demuxOut_0),
    .demuxOut_1  (demuxOut_1),
    .demuxOut_2  (demuxOut_2),
    .demuxOut_3  (demuxOut_3),
    .lane_valid  (lane_valid),
    .seq_idx     (seq_idx),
    .frame_valid (frame_valid)
`ifdef DEMUX4_PARITY_EN
    ,
    .frame_parity(frame_parity)
`endif
  );

  typedef struct {
    int rst, ld, am, clr, sel, din;
    int e0, e1, e2, e3, lv, idx, fv, par;
  } vec_t;

  vec_t vecs[22];
  vec_t sbq[$];

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step%0d actual=%0h required=%0h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge sysclk);
    sys_rst   = v.rst != 0;
    load      = v.ld != 0;
    auto_mode = v.am != 0;
    clear     = v.clr != 0;
    sel       = 2'(v.sel);
    demuxIn   = 4'(v.din);
    sbq.push_back(v);
  endtask

  task automatic sample(input int tag);
    vec_t e;
    @(posedge sysclk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step%0d actual=0 required=1", tag);
    end else begin
      e = sbq.pop_front();
      chk("demuxOut_0", tag, 32'(demuxOut_0), e.e0);
      chk("demuxOut_1", tag, 32'(demuxOut_1), e.e1);
      chk("demuxOut_2", tag, 32'(demuxOut_2), e.e2);
      chk("demuxOut_3", tag, 32'(demuxOut_3), e.e3);
      chk("lane_valid", tag, 32'(lane_valid), e.lv);
      chk("seq_idx", tag, 32'(seq_idx), e.idx);
      chk("frame_valid", tag, 32'(frame_valid), e.fv);
`ifdef DEMUX4_PARITY_EN
      chk("frame_parity", tag, 32'(frame_parity), e.par);
`endif
    end
  endtask

  initial begin
    sys_rst = 1'b1; load = 1'b0; auto_mode = 1'b0; clear = 1'b0;
    sel = 2'd0; demuxIn = 4'h0;

    //         rst ld am clr sel din   out0 out1 out2 out3  lv   idx fv par
    vecs[0]  = '{1, 0, 0, 0, 0, 0,     0,   0,   0,   0,   'b0000, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 1, 'hA,   0,   'hA, 0,   0,   'b0010, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 3, 5,     0,   'hA, 0,   5,   'b1010, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 'hF,   0,   0,   0,   0,   'b0000, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 0, 0, 1,     1,   0,   0,   0,   'b0001, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 0, 0, 2,     1,   2,   0,   0,   'b0011, 2, 0, 0};
    vecs[6]  = '{0, 1, 1, 0, 0, 3,     1,   2,   3,   0,   'b0111, 3, 0, 0};
    vecs[7]  = '{0, 1, 1, 0, 0, 4,     1,   2,   3,   4,   'b0000, 0, 1, 4};
    vecs[8]  = '{0, 0, 1, 0, 0, 0,     1,   2,   3,   4,   'b0000, 0, 0, 4};
    vecs[9]  = '{0, 1, 0, 0, 2, 6,     1,   2,   6,   4,   'b0100, 0, 0, 4};
    vecs[10] = '{0, 1, 0, 0, 2, 7,     1,   2,   7,   4,   'b0100, 0, 0, 4};
    vecs[11] = '{0, 1, 0, 0, 0, 8,     8,   2,   7,   4,   'b0101, 0, 0, 4};
    vecs[12] = '{0, 1, 0, 0, 3, 9,     8,   2,   7,   9,   'b1101, 0, 0, 4};
    vecs[13] = '{0, 1, 0, 0, 1, 'hB,   8,   'hB, 7,   9,   'b0000, 0, 1, 'hD};
    vecs[14] = '{0, 1, 1, 0, 0, 'hC,   'hC, 'hB, 7,   9,   'b0001, 1, 0, 'hD};
    vecs[15] = '{0, 1, 1, 0, 0, 'hD,   'hC, 'hD, 7,   9,   'b0011, 2, 0, 'hD};
    vecs[16] = '{0, 1, 1, 1, 0, 'hE,   'hC, 'hD, 7,   9,   'b0000, 0, 0, 0};
    vecs[17] = '{0, 1, 1, 0, 0, 1,     1,   'hD, 7,   9,   'b0001, 1, 0, 0};
    vecs[18] = '{0, 1, 1, 0, 0, 2,     1,   2,   7,   9,   'b0011, 2, 0, 0};
    vecs[19] = '{0, 1, 0, 0, 3, 'hF,   1,   2,   7,   9,   'b0000, 0, 0, 0};
    vecs[20] = '{0, 1, 0, 0, 3, 5,     1,   2,   7,   5,   'b1000, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 1, 'hE,   1,   2,   7,   5,   'b1000, 0, 0, 0};

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i]);
      sample(i);
    end

    // Clear while flipping to auto mode: clear wins, frame restarts from lane 0.
    @(negedge sysclk);
    sys_rst = 1'b0; clear = 1'b1; load = 1'b0; auto_mode = 1'b1;
    @(posedge sysclk);
    #1;
    chk("clear_lane_valid", 100, 32'(lane_valid), 0);
    chk("clear_seq_idx", 100, 32'(seq_idx), 0);

    // Two back-to-back auto frames; the 5th load lands in the FULL cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge sysclk);
      clear = 1'b0; load = 1'b1; demuxIn = 4'(k + 5);
      @(posedge sysclk);
      #1;
      chk("b2b_frame_valid", 200 + k, 32'(frame_valid), ((k % 4) == 3) ? 1 : 0);
      chk("b2b_seq_idx", 200 + k, 32'(seq_idx), (k + 1) % 4);
      if (k == 4) chk("b2b_lane_valid", 200 + k, 32'(lane_valid), 'b0001);
    end
    @(negedge sysclk);
    load = 1'b0;
    chk("b2b_out0", 300, 32'(demuxOut_0), 'h9);
    chk("b2b_out1", 300, 32'(demuxOut_1), 'hA);
    chk("b2b_out2", 300, 32'(demuxOut_2), 'hB);
    chk("b2b_out3", 300, 32'(demuxOut_3), 'hC);
`ifdef DEMUX4_PARITY_EN
    chk("b2b_parity", 300, 32'(frame_parity), 'h9 ^ 'hA ^ 'hB ^ 'hC);
`endif
    @(posedge sysclk);
    #1;
    chk("b2b_idle_frame_valid", 301, 32'(frame_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
